// File: rtl/cpu_pkg.sv
// Shared types for the MIPS core pipeline control: forwarding selects,
// redirect FSM states and the per-stage scoreboard slot.
package cpu_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        REDIR_IDLE = 1'b0,
        REDIR_PEND = 1'b1
    } redir_state_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dst;
        logic                 regwrite;
        logic                 memtoreg;
    } stage_sb_t;

    localparam stage_sb_t SB_EMPTY = '0;

    // A slot only produces a result worth waiting for or forwarding when it
    // really writes a non-zero register.
    function automatic logic sb_hit(input stage_sb_t s, input logic [REG_IDX_W-1:0] src);
        return s.valid && s.regwrite && (s.dst != '0) && (s.dst == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand source select for one register index against the M and W slots.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src,
    input  stage_sb_t            slot_m,
    input  stage_sb_t            slot_w,
    output fwd_sel_t             sel
);

    // A load in M has no data yet, so it never forwards from M.
    always_comb begin
        sel = FWD_RF;
        if (sb_hit(slot_m, src) && !slot_m.memtoreg) begin
            sel = FWD_M;
        end else if (sb_hit(slot_w, src)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside decode: shadow scoreboard of E/M/W, stall and
// bubble generation, operand forwarding selects and a held branch redirect.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W  = REG_IDX_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              d_valid,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rtD,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic              d_branch,
    input  logic [REG_W-1:0]  d_dst,
    input  logic              d_regwrite,
    input  logic              d_memtoreg,
    input  logic              j_taken,
    input  logic [ADDR_W-1:0] j_target,
    input  logic              i_busy,
    input  logic              dm_busy,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              bubbleE,
    output logic              bubbleW,
    output logic [1:0]        fwd_rsD,
    output logic [1:0]        fwd_rtD,
    output logic [1:0]        fwd_rsE,
    output logic [1:0]        fwd_rtE,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_target
);

    stage_sb_t        sb_e, sb_m, sb_w, d_slot;
    logic [REG_W-1:0] rs_e, rt_e;
    logic             use_rs_e, use_rt_e;
    logic [REG_W-1:0] src_rs_d, src_rt_d, src_rs_e, src_rt_e;
    logic             load_use, branch_haz;
    fwd_sel_t         sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e;
    redir_state_t     state, state_nx;
    logic             take_branch;

    assign d_slot = '{valid: d_valid, dst: d_dst, regwrite: d_regwrite, memtoreg: d_memtoreg};

    // Unread operands are steered to $0, which never matches a live slot.
    assign src_rs_d = (d_valid && d_use_rs) ? rsD : '0;
    assign src_rt_d = (d_valid && d_use_rt) ? rtD : '0;
    assign src_rs_e = (sb_e.valid && use_rs_e) ? rs_e : '0;
    assign src_rt_e = (sb_e.valid && use_rt_e) ? rt_e : '0;

    assign load_use   = sb_e.memtoreg && (sb_hit(sb_e, src_rs_d) || sb_hit(sb_e, src_rt_d));
    assign branch_haz = d_branch &&
                        (sb_hit(sb_e, src_rs_d) || sb_hit(sb_e, src_rt_d) ||
                         (sb_m.memtoreg && (sb_hit(sb_m, src_rs_d) || sb_hit(sb_m, src_rt_d))));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        stallM  = 1'b0;
        bubbleE = 1'b0;
        bubbleW = 1'b0;
        if (resetn) begin
            if (dm_busy) begin
                stallF  = 1'b1;
                stallD  = 1'b1;
                stallE  = 1'b1;
                stallM  = 1'b1;
                bubbleW = 1'b1;
            end else if (load_use || branch_haz || i_busy) begin
                stallF  = 1'b1;
                stallD  = 1'b1;
                bubbleE = 1'b1;
            end
        end
    end

    fwd_sel u_fwd_rs_d (.src(src_rs_d), .slot_m(sb_m), .slot_w(sb_w), .sel(sel_rs_d));
    fwd_sel u_fwd_rt_d (.src(src_rt_d), .slot_m(sb_m), .slot_w(sb_w), .sel(sel_rt_d));
    fwd_sel u_fwd_rs_e (.src(src_rs_e), .slot_m(sb_m), .slot_w(sb_w), .sel(sel_rs_e));
    fwd_sel u_fwd_rt_e (.src(src_rt_e), .slot_m(sb_m), .slot_w(sb_w), .sel(sel_rt_e));

    assign fwd_rsD = sel_rs_d;
    assign fwd_rtD = sel_rt_d;
    assign fwd_rsE = sel_rs_e;
    assign fwd_rtE = sel_rt_e;

    // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_e     <= SB_EMPTY;
            sb_m     <= SB_EMPTY;
            sb_w     <= SB_EMPTY;
            rs_e     <= '0;
            rt_e     <= '0;
            use_rs_e <= 1'b0;
            use_rt_e <= 1'b0;
        end else begin
            if (!stallE) begin
                sb_e     <= bubbleE ? SB_EMPTY : d_slot;
                rs_e     <= rsD;
                rt_e     <= rtD;
                use_rs_e <= d_use_rs;
                use_rt_e <= d_use_rt;
            end
            if (!stallM) begin
                sb_m <= sb_e;
            end
            sb_w <= bubbleW ? SB_EMPTY : sb_m;
        end
    end

    // Redirect is held until fetch is free to take it; the delay slot in D
    // guarantees no second taken branch arrives meanwhile.
    always_comb begin
        state_nx    = state;
        take_branch = 1'b0;
        case (state)
            REDIR_IDLE: begin
                if (d_valid && j_taken && !stallD) begin
                    take_branch = 1'b1;
                    state_nx    = REDIR_PEND;
                end
            end
            REDIR_PEND: begin
                if (!stallF) begin
                    state_nx = REDIR_IDLE;
                end
            end
            default: state_nx = REDIR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= REDIR_IDLE;
            redirect_target <= '0;
        end else begin
            state <= state_nx;
            if (take_branch) begin
                redirect_target <= j_target;
            end
        end
    end

    assign pc_redirect = (state == REDIR_PEND);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against an instruction-level pipeline model.
module tb_hazard_ctrl;

    localparam int REG_W  = 5;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic              d_valid, d_use_rs, d_use_rt, d_branch;
    logic [REG_W-1:0]  rsD, rtD, d_dst;
    logic              d_regwrite, d_memtoreg, j_taken, i_busy, dm_busy;
    logic [ADDR_W-1:0] j_target;
    logic              stallF, stallD, stallE, stallM, bubbleE, bubbleW;
    logic [1:0]        fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
    logic              pc_redirect;
    logic [ADDR_W-1:0] redirect_target;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn),
        .d_valid(d_valid), .rsD(rsD), .rtD(rtD),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_branch(d_branch),
        .d_dst(d_dst), .d_regwrite(d_regwrite), .d_memtoreg(d_memtoreg),
        .j_taken(j_taken), .j_target(j_target),
        .i_busy(i_busy), .dm_busy(dm_busy),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .bubbleE(bubbleE), .bubbleW(bubbleW),
        .fwd_rsD(fwd_rsD), .fwd_rtD(fwd_rtD), .fwd_rsE(fwd_rsE), .fwd_rtE(fwd_rtE),
        .pc_redirect(pc_redirect), .redirect_target(redirect_target)
    );

    // Model: the instruction occupying each of E, M, W (index 0, 1, 2).
    typedef struct {
        bit       valid;
        bit [4:0] dst;
        bit       rw;
        bit       mr;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
    } instr_t;

    instr_t      pipe[3];
    instr_t      empty_instr;
    bit          pend;
    bit [31:0]   tgt;
    bit [5:0]    e_ctl;      // {F, D, E, M, bubbleE, bubbleW}
    bit [1:0]    e_fwd[4];   // rsD, rtD, rsE, rtE
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic bit writes(instr_t s);
        return s.valid && s.rw && (s.dst != 0);
    endfunction

    function automatic bit d_needs(bit [4:0] r);
        return (r != 0) && d_valid && ((d_use_rs && rsD == r) || (d_use_rt && rtD == r));
    endfunction

    function automatic bit [1:0] src_of(bit used, bit [4:0] r);
        if (!used || r == 0) return 2'b00;
        if (writes(pipe[1]) && !pipe[1].mr && pipe[1].dst == r) return 2'b01;
        if (writes(pipe[2]) && pipe[2].dst == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic compute_exp();
        bit hz;
        hz = (writes(pipe[0]) && pipe[0].mr && d_needs(pipe[0].dst)) ||
             (d_branch && ((writes(pipe[0]) && d_needs(pipe[0].dst)) ||
                           (writes(pipe[1]) && pipe[1].mr && d_needs(pipe[1].dst))));
        if (!resetn)            e_ctl = 6'b000000;
        else if (dm_busy)       e_ctl = 6'b111101;
        else if (hz || i_busy)  e_ctl = 6'b110010;
        else                    e_ctl = 6'b000000;
        e_fwd[0] = src_of(d_valid && d_use_rs, rsD);
        e_fwd[1] = src_of(d_valid && d_use_rt, rtD);
        e_fwd[2] = src_of(pipe[0].valid && pipe[0].urs, pipe[0].rs);
        e_fwd[3] = src_of(pipe[0].valid && pipe[0].urt, pipe[0].rt);
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        compute_exp();
        check("ctl", {stallF, stallD, stallE, stallM, bubbleE, bubbleW}, e_ctl);
        check("fwd", {fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE}, {e_fwd[0], e_fwd[1], e_fwd[2], e_fwd[3]});
        check("redir", {pc_redirect, redirect_target}, {pend, tgt});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = empty_instr;
        pend = 1'b0;
        tgt  = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        compute_exp();
        if (resetn) begin
            if (!pend) begin
                if (d_valid && j_taken && !e_ctl[4]) begin
                    pend = 1'b1;
                    tgt  = j_target;
                end
            end else if (!e_ctl[5]) begin
                pend = 1'b0;
            end
            if (dm_busy) begin
                pipe[2] = empty_instr;
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = e_ctl[1] ? empty_instr :
                          '{d_valid, d_dst, d_regwrite, d_memtoreg, rsD, rtD, d_use_rs, d_use_rt};
            end
        end
        #1;
    endtask

    task automatic set_d(bit v, bit [4:0] rs, bit urs, bit [4:0] rt, bit urt,
                         bit br, bit [4:0] dst, bit rw, bit mr);
        d_valid = v; rsD = rs; d_use_rs = urs; rtD = rt; d_use_rt = urt;
        d_branch = br; d_dst = dst; d_regwrite = rw; d_memtoreg = mr;
        j_taken = 1'b0;
    endtask

    task automatic flush();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        i_busy = 1'b0;
        dm_busy = 1'b0;
        repeat (3) begin
            settle();
            advance();
        end
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        set_d(1, 2, 1, 3, 1, 1, 4, 1, 1);
        j_target = 32'hDEAD_BEEF;
        i_busy = 1'b1;
        dm_busy = 1'b0;
        settle();
        check("reset_ctl", {stallF, stallD, bubbleE, pc_redirect}, 4'b0000);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        flush();

        // Load-use: LW $2 then ADDU reading $2.
        set_d(1, 1, 1, 0, 0, 0, 2, 1, 1);
        settle(); advance();
        set_d(1, 2, 1, 7, 1, 0, 5, 1, 0);
        settle();
        check("lu_stall", {stallF, stallD, bubbleE, stallE}, 4'b1110);
        advance();
        settle();
        check("lu_release", {stallD, bubbleE}, 2'b00);
        advance();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("lu_fwd_rsE", fwd_rsE, 2'b10);
        advance();
        flush();

        // Branch after ALU: ADDU $3 then BEQ $3,$0.
        set_d(1, 1, 1, 1, 1, 0, 3, 1, 0);
        settle(); advance();
        set_d(1, 3, 1, 0, 1, 1, 0, 0, 0);
        settle();
        check("br_stall", {stallD, bubbleE}, 2'b11);
        advance();
        settle();
        check("br_fwd", {stallD, fwd_rsD, fwd_rtD}, 5'b00100);
        advance();
        flush();

        // Double match: $4 written in M and W.
        set_d(1, 0, 0, 0, 0, 0, 4, 1, 0);
        settle(); advance();
        settle(); advance();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); advance();
        set_d(1, 4, 1, 0, 1, 0, 9, 1, 0);
        settle();
        check("dbl_fwd", {fwd_rsD, fwd_rtD}, 4'b0100);
        advance();
        flush();

        // Taken branch, then the redirect held across 3 i_busy cycles.
        set_d(1, 0, 1, 0, 1, 1, 0, 0, 0);
        j_taken = 1'b1;
        j_target = 32'hBFC0_0100;
        settle();
        check("redir_take", stallD, 1'b0);
        advance();
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0);
        j_target = 32'h0000_1234;
        i_busy = 1'b1;
        repeat (3) begin
            settle();
            check("redir_hold", {pc_redirect, redirect_target, stallF}, {1'b1, 32'hBFC0_0100, 1'b1});
            advance();
        end
        i_busy = 1'b0;
        settle();
        check("redir_accept", {pc_redirect, stallF}, 2'b10);
        advance();
        settle();
        check("redir_clear", pc_redirect, 1'b0);
        advance();
        flush();

        // dm_busy while a load-use is waiting.
        set_d(1, 0, 0, 0, 0, 0, 6, 1, 1);
        settle(); advance();
        set_d(1, 6, 1, 0, 0, 0, 7, 1, 0);
        dm_busy = 1'b1;
        repeat (2) begin
            settle();
            check("dm_ctl", {stallF, stallD, stallE, stallM, bubbleE, bubbleW}, 6'b111101);
            advance();
        end
        dm_busy = 1'b0;
        settle();
        check("dm_then_lu", {stallD, bubbleE, stallE}, 3'b110);
        advance();
        flush();

        // Reset pulsed while a redirect is pending and E/M/W hold results.
        set_d(1, 0, 0, 0, 0, 0, 8, 1, 0);
        settle(); advance();
        set_d(1, 0, 0, 0, 0, 0, 9, 1, 0);
        settle(); advance();
        set_d(1, 0, 1, 0, 1, 1, 0, 0, 0);
        j_taken = 1'b1;
        j_target = 32'h8000_0040;
        settle(); advance();
        set_d(1, 9, 1, 8, 1, 0, 0, 0, 0);
        settle();
        check("pre_rst", {pc_redirect, fwd_rsD, fwd_rtD}, 5'b10110);
        #2;
        i_busy = 1'b1;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst", {pc_redirect, redirect_target, fwd_rsD, fwd_rtD, stallF},
              {1'b0, 32'h0, 2'b00, 2'b00, 1'b0});
        check_all();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        flush();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit rw;
            rw = ($urandom_range(0, 3) != 0);
            set_d($urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                  5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
                  5'($urandom_range(0, 7)), rw, rw && ($urandom_range(0, 2) == 0));
            j_taken  = d_branch && !pend && ($urandom_range(0, 1) != 0);
            j_target = $urandom;
            i_busy   = ($urandom_range(0, 3) == 0);
            dm_busy  = ($urandom_range(0, 5) == 0);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits beside the decode stage and keeps a shadow scoreboard of the E, M and W stages, recording valid, destination, regwrite and memtoreg for each. From that state it generates the per-stage stall and bubble controls and the operand forwarding selects for decode-stage branch compare and EX. It also holds a taken-branch redirect until fetch can accept it.

## Interface
Parameters:
- REG_W, 5: register index width
- ADDR_W, 32: PC width

Ports:
- clk  in  1  core clock
- resetn  in  1  reset, asynchronous, active-low
- d_valid  in  1  instruction present in D
- rsD, rtD  in  REG_W  D source indices
- d_use_rs, d_use_rt  in  1  D reads rs/rt (EX use)
- d_branch  in  1  D consumes operands in D (BEQ/BNE/JR)
- d_dst  in  REG_W  D destination (already muxed, 0 = none)
- d_regwrite, d_memtoreg  in  1  D write-back class
- j_taken  in  1  D branch taken
- j_target  in  ADDR_W  D branch target
- i_busy  in  1  fetch request outstanding
- dm_busy  in  1  data memory in M not complete
- stallF, stallD, stallE, stallM  out  1  hold stage register
- bubbleE, bubbleW  out  1  load NOP into E / W
- fwd_rsD, fwd_rtD  out  2  D compare source: 00 regfile, 01 M ALU result, 10 W result
- fwd_rsE, fwd_rtE  out  2  EX operand source, same encoding
- pc_redirect  out  1  fetch must load redirect_target
- redirect_target  out  ADDR_W  held branch target

## Operation
- Scoreboard: E/M/W each hold {valid, dst, regwrite, memtoreg}; E also holds rsE, rtE, use flags. A slot is live only if valid & regwrite & dst≠0.
- Priority of stall causes, highest first: dm_busy > data hazard > i_busy.
- dm_busy: stallF/D/E/M = 1, bubbleW = 1. The scoreboard does not advance, and W becomes invalid.
- Load-use: E live & memtoreg & dst matches a used D source. Response: stallF/D = 1, bubbleE = 1.
- Branch hazard (d_branch): matching source live in E (any class) or live load in M. Response: stallF/D = 1, bubbleE = 1.
- i_busy only: stallF = 1, stallD = 1, bubbleE = 1.
- fwd_*D: match in M (non-load) → 01, else match in W → 10, else 00. M wins over W.
- fwd_*E: same priority, against M/W. Index 0 always → 00.
- Advance: when not stalled, E ← D fields (or invalid on bubbleE), M ← E, W ← M (or invalid on bubbleW).
- Redirect FSM, states IDLE and PEND:
  - IDLE → PEND when d_valid & j_taken & !stallD; latch j_target.
  - PEND: pc_redirect = 1. The delay slot is the instruction in F, so the redirect applies to the next fetch.
  - PEND → IDLE when !stallF.
  - A second taken branch cannot arrive while in PEND, because D holds the delay slot.

## Timing
- Stall, bubble and fwd outputs are combinational from the scoreboard and current inputs, in the same cycle.
- Scoreboard and FSM update on posedge clk.
- pc_redirect asserts the cycle after the branch leaves D.
- Reset (async, resetn = 0), including mid-operation:
  - all valid = 0, FSM = IDLE, redirect_target = 0;
  - all outputs 0 and fwd = 00 while in reset.
- A pending redirect survives any number of i_busy/dm_busy cycles.

## Structure
- Shared package cpu_pkg holds:
  - fwd_sel_t enum (FWD_RF, FWD_M, FWD_W);
  - redir_state_t;
  - stage_sb_t struct {valid, dst, regwrite, memtoreg}.
- One sub-module, fwd_sel, is instantiated four times. Inputs: src index, M and W slots. Output: fwd_sel_t.

## Test plan
- Load-use: LW $2 in E, D=ADDU using $2 → stallF/D = 1, bubbleE = 1 for 1 cycle; next cycle fwd_rsE = 10.
- Branch after ALU: ADDU $3 in E, D=BEQ $3,$0 → 1 stall cycle, then fwd_rsD = 01.
- Double match: $4 written in both M and W, D reads $4 → fwd = 01; $0 in all stages → fwd = 00.
- Redirect under i_busy: BEQ taken with j_target = 0xBFC0_0100, i_busy = 1 for 3 cycles → pc_redirect held 3 cycles with target stable; clears the cycle after i_busy drops.
- dm_busy with simultaneous load-use: dm_busy = 1 for 2 cycles → stallF/D/E/M = 1, bubbleW = 1, bubbleE = 0; the load-use stall then follows.
- resetn pulsed low while in PEND with E/M valid → pc_redirect = 0 and all valid = 0 immediately, without waiting for a clock edge.
